eq_coef_loader: RTL and testbench

Byte-stream coefficient loader that sits directly upstream of the five-band equalizer's coefficient port. It parses framed byte streams, for example from the UART/host bridge, into one biquad coefficient set. Each frame carries a filter index and five IEEE-754 single-precision words (b0, b1, b2, a1, a2) plus an XOR checksum. A validated set is written into the equalizer with a single-cycle set-coefficient strobe, and only while the equalizer reports idle, so a sample is never processed with a half-updated cascade.

---
 rtl/eq_coef_loader_if.sv | 30 +++
 rtl/eq_coef_loader.sv | 159 +++++++++++++++
 tb/tb_eq_coef_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_coef_loader_if.sv
// Byte-stream and coefficient-write bundle between a host byte source, the
// coefficient loader and the equalizer's coefficient port.
interface eq_coef_loader_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        i_eq_idle;
  logic        o_set_coef;
  logic [2:0]  o_set_filt;
  logic [31:0] o_b0;
  logic [31:0] o_b1;
  logic [31:0] o_b2;
  logic [31:0] o_a1;
  logic [31:0] o_a2;
  logic        o_done;
  logic        o_err;

  // Host/equalizer side: supplies bytes and the idle flag, observes the writes.
  modport master (
    output i_byte, i_byte_valid, i_eq_idle,
    input  o_byte_ready, o_set_coef, o_set_filt,
    input  o_b0, o_b1, o_b2, o_a1, o_a2, o_done, o_err
  );

  modport slave (
    input  i_byte, i_byte_valid, i_eq_idle,
    output o_byte_ready, o_set_coef, o_set_filt,
    output o_b0, o_b1, o_b2, o_a1, o_a2, o_done, o_err
  );
endinterface

// File: rtl/eq_coef_loader.sv
// Parses framed byte streams into one biquad coefficient set and writes it to
// the equalizer with a single strobe, only while the equalizer is idle.
module eq_coef_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  eq_coef_loader_if.slave bus
);

  localparam int              GAP_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT - 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [4:0]      LAST_DATA = 5'd19;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDX,
    S_DATA,
    S_CSUM,
    S_WAIT,
    S_APPLY
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [159:0]     staging;
  logic [7:0]       xor_acc;
  logic [4:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       filt;
  logic             err_q;
  logic             err_next;

  logic byte_ready;
  logic xfer;
  logic counting;
  logic gap_expired;
  logic idx_ok;

  // Ready depends on state alone so upstream never sees a valid->ready path.
  assign byte_ready  = (state != S_WAIT) && (state != S_APPLY);
  assign xfer        = bus.i_byte_valid && byte_ready;
  assign counting    = (state == S_IDX) || (state == S_DATA) || (state == S_CSUM);
  assign gap_expired = counting && !xfer && (gap_cnt == GAP_MAX);
  assign idx_ok      = (bus.i_byte >= 8'd1) && (bus.i_byte <= 8'd5);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_SYNC: begin
        if (xfer && (bus.i_byte == SYNC_BYTE)) begin
          state_next = S_IDX;
        end
      end
      S_IDX: begin
        if (xfer) begin
          if (idx_ok) begin
            state_next = S_DATA;
          end else begin
            state_next = S_SYNC;
            err_next   = 1'b1;
          end
        end else if (gap_expired) begin
          state_next = S_SYNC;
          err_next   = 1'b1;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (byte_cnt == LAST_DATA) begin
            state_next = S_CSUM;
          end
        end else if (gap_expired) begin
          state_next = S_SYNC;
          err_next   = 1'b1;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (bus.i_byte == xor_acc) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_SYNC;
            err_next   = 1'b1;
          end
        end else if (gap_expired) begin
          state_next = S_SYNC;
          err_next   = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.i_eq_idle) begin
          state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        state_next = S_SYNC;
      end
      default: begin
        state_next = S_SYNC;
      end
    endcase
  end

  // Staging, checksum and gap counting; the staging register only moves in DATA,
  // so the coefficient outputs stay frozen through WAIT and APPLY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      staging  <= '0;
      xor_acc  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      filt     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_next;

      if ((state == S_IDX) && xfer && idx_ok) begin
        filt     <= bus.i_byte[2:0];
        xor_acc  <= bus.i_byte;
        byte_cnt <= '0;
      end

      if ((state == S_DATA) && xfer) begin
        staging  <= {staging[151:0], bus.i_byte};
        xor_acc  <= xor_acc ^ bus.i_byte;
        byte_cnt <= byte_cnt + 5'd1;
      end

      if (!counting || xfer || gap_expired) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  assign bus.o_byte_ready = byte_ready;
  assign bus.o_set_coef   = (state == S_APPLY);
  assign bus.o_done       = (state == S_APPLY);
  assign bus.o_err        = err_q;
  assign bus.o_set_filt   = filt;
  assign bus.o_b0         = staging[159:128];
  assign bus.o_b1         = staging[127:96];
  assign bus.o_b2         = staging[95:64];
  assign bus.o_a1         = staging[63:32];
  assign bus.o_a2         = staging[31:0];

endmodule

// File: tb/tb_eq_coef_loader.sv
// Directed and randomized frames checked against a frame-level model of what
// the loader must write to the equalizer.
module tb_eq_coef_loader;

  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst;

  eq_coef_loader_if bus ();

  eq_coef_loader #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [2:0]   filt;
    logic [159:0] coefs;
    logic         done;
  } strobe_t;

  strobe_t    strobes[$];
  logic [7:0] frame_q[$];
  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int err_count = 0;
  int last_err_cyc = -1;
  int done_mismatch = 0;
  int both_high = 0;
  int last_xfer_cyc = 0;

  function automatic logic [159:0] coefs();
    return {bus.o_b0, bus.o_b1, bus.o_b2, bus.o_a1, bus.o_a2};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Records every write strobe and error pulse so the directed steps can query them.
  always @(negedge clk) begin
    strobe_t s;
    if (bus.o_set_coef === 1'b1) begin
      s.cyc   = cyc;
      s.filt  = bus.o_set_filt;
      s.coefs = coefs();
      s.done  = bus.o_done;
      strobes.push_back(s);
    end
    if (bus.o_err === 1'b1) begin
      err_count++;
      last_err_cyc = cyc;
    end
    if (bus.o_done !== bus.o_set_coef) done_mismatch++;
    if (bus.o_err === 1'b1 && bus.o_done === 1'b1) both_high++;
  end

  task automatic check_output(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int n = 0;
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    while (bus.o_byte_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_output("ready_wait", {159'b0, bus.o_byte_ready}, 160'd1);
    tick();
    last_xfer_cyc = cyc;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) apply_stimulus(frame_q[i]);
    bus.i_byte_valid = 1'b0;
  endtask

  // Frame model: sync, index, 20 data bytes MSB first, XOR of bytes 1..21.
  task automatic build_frame(input logic [7:0] idx, input logic [159:0] words, input logic [7:0] flip);
    logic [7:0] x;
    logic [7:0] b;
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(idx);
    x = idx;
    for (int i = 0; i < 20; i++) begin
      b = words[159 - 8*i -: 8];
      frame_q.push_back(b);
      x ^= b;
    end
    frame_q.push_back(x ^ flip);
  endtask

  task automatic wait_strobes(input int want);
    int n = 0;
    while (strobes.size() < want && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_strobe(input string tag, input int idx, input int exp_cyc,
                              input logic [2:0] exp_filt, input logic [159:0] exp_coefs);
    if (strobes.size() > idx) begin
      check_output({tag, "_cyc"},   160'(strobes[idx].cyc), 160'(exp_cyc));
      check_output({tag, "_filt"},  160'(strobes[idx].filt), 160'(exp_filt));
      check_output({tag, "_coefs"}, strobes[idx].coefs, exp_coefs);
      check_output({tag, "_done"},  160'(strobes[idx].done), 160'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, 160'(bus.o_byte_ready), 160'd1);
    check_output({tag, "_pulses"}, 160'({bus.o_set_coef, bus.o_done, bus.o_err}), 160'd0);
    check_output({tag, "_filt"}, 160'(bus.o_set_filt), 160'd0);
    check_output({tag, "_coefs"}, coefs(), 160'd0);
  endtask

  initial begin
    logic [159:0] w;
    logic [159:0] w2;
    logic [7:0]   idx;
    logic [7:0]   idx2;
    int n0, e0, t0, wcyc, k, bad_ready, bad_strobe, bad_coef;
    logic corrupt;

    rst = 1'b1;
    bus.i_byte = 8'h00;
    bus.i_byte_valid = 1'b0;
    bus.i_eq_idle = 1'b1;
    tick(); tick();
    check_reset_outputs("reset_held");
    rst = 1'b0;
    tick();
    check_reset_outputs("reset_released");

    // Nominal write of filter 2, b0 = 1.0f, checksum BD.
    w = {32'h3F800000, 128'h0};
    build_frame(8'h02, w, 8'h00);
    check_output("nominal_csum_byte", 160'(frame_q[22]), 160'hBD);
    n0 = strobes.size();
    send_frame();
    wait_strobes(n0 + 1);
    repeat (5) tick();
    check_output("nominal_count", 160'(strobes.size() - n0), 160'd1);
    check_strobe("nominal", n0, last_xfer_cyc + 1, 3'd2, w);

    // Checksum error, then a good frame for filter 5.
    e0 = err_count;
    n0 = strobes.size();
    build_frame(8'h02, w, 8'h01);
    send_frame();
    repeat (5) tick();
    check_output("csum_err_count", 160'(err_count - e0), 160'd1);
    check_output("csum_err_cyc", 160'(last_err_cyc), 160'(last_xfer_cyc));
    check_output("csum_no_strobe", 160'(strobes.size() - n0), 160'd0);
    check_output("csum_staged", coefs(), w);
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_frame(8'h05, w, 8'h00);
    send_frame();
    wait_strobes(n0 + 1);
    check_strobe("after_csum", n0, last_xfer_cyc + 1, 3'd5, w);

    // Idle gating: equalizer busy for 40 cycles after the frame.
    bus.i_eq_idle = 1'b0;
    n0 = strobes.size();
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_frame(8'h03, w, 8'h00);
    send_frame();
    bad_ready = 0; bad_strobe = 0; bad_coef = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_byte_ready !== 1'b0) bad_ready++;
      if (strobes.size() != n0) bad_strobe++;
      if (coefs() !== w) bad_coef++;
    end
    check_output("gate_ready_low", 160'(bad_ready), 160'd0);
    check_output("gate_no_strobe", 160'(bad_strobe), 160'd0);
    check_output("gate_coef_stable", 160'(bad_coef), 160'd0);
    wcyc = cyc;
    bus.i_eq_idle = 1'b1;
    wait_strobes(n0 + 1);
    check_output("gate_count", 160'(strobes.size() - n0), 160'd1);
    check_strobe("gate", n0, wcyc + 1, 3'd3, w);

    // Garbage before sync is silent; bad indices flag once.
    e0 = err_count;
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    bus.i_byte_valid = 1'b0;
    tick(); tick();
    check_output("garbage_no_err", 160'(err_count - e0), 160'd0);
    apply_stimulus(8'hA5);
    apply_stimulus(8'h07);
    bus.i_byte_valid = 1'b0;
    repeat (3) tick();
    check_output("idx7_err_count", 160'(err_count - e0), 160'd1);
    check_output("idx7_err_cyc", 160'(last_err_cyc), 160'(last_xfer_cyc));
    e0 = err_count;
    apply_stimulus(8'hA5);
    apply_stimulus(8'h00);
    bus.i_byte_valid = 1'b0;
    repeat (3) tick();
    check_output("idx0_err_count", 160'(err_count - e0), 160'd1);

    // Timeout after three data bytes.
    e0 = err_count;
    n0 = strobes.size();
    apply_stimulus(8'hA5);
    apply_stimulus(8'h01);
    apply_stimulus(8'h12);
    apply_stimulus(8'h34);
    apply_stimulus(8'h56);
    bus.i_byte_valid = 1'b0;
    t0 = last_xfer_cyc;
    k = 0;
    while (err_count == e0 && k < TIMEOUT + 20) begin
      tick();
      k++;
    end
    repeat (20) tick();
    check_output("timeout_err_count", 160'(err_count - e0), 160'd1);
    check_output("timeout_err_delay", 160'(last_err_cyc - t0), 160'(TIMEOUT));
    check_output("timeout_ready", 160'(bus.o_byte_ready), 160'd1);
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_frame(8'h01, w, 8'h00);
    send_frame();
    wait_strobes(n0 + 1);
    check_strobe("after_timeout", n0, last_xfer_cyc + 1, 3'd1, w);

    // Back-to-back frames at full byte rate.
    n0 = strobes.size();
    idx  = 8'($urandom_range(5, 1));
    idx2 = 8'($urandom_range(5, 1));
    w  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    w2 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_frame(idx, w, 8'h00);
    foreach (frame_q[i]) apply_stimulus(frame_q[i]);
    build_frame(idx2, w2, 8'h00);
    send_frame();
    wait_strobes(n0 + 2);
    check_output("b2b_count", 160'(strobes.size() - n0), 160'd2);
    if (strobes.size() >= n0 + 2) begin
      check_output("b2b_spacing", 160'(strobes[n0+1].cyc - strobes[n0].cyc), 160'd25);
      check_strobe("b2b_first", n0, strobes[n0+1].cyc - 25, idx[2:0], w);
      check_strobe("b2b_second", n0 + 1, last_xfer_cyc + 1, idx2[2:0], w2);
    end

    // Randomized frames: good ones write after the idle delay, corrupted ones flag.
    for (int r = 0; r < 8; r++) begin
      idx = 8'($urandom_range(5, 1));
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      corrupt = ($urandom_range(3, 0) == 0);
      k = $urandom_range(4, 0);
      build_frame(idx, w, corrupt ? 8'($urandom_range(255, 1)) : 8'h00);
      n0 = strobes.size();
      e0 = err_count;
      if (k > 0) bus.i_eq_idle = 1'b0;
      send_frame();
      repeat (k) tick();
      wcyc = cyc;
      bus.i_eq_idle = 1'b1;
      if (corrupt) begin
        repeat (5) tick();
        check_output("rand_bad_err", 160'(err_count - e0), 160'd1);
        check_output("rand_bad_no_strobe", 160'(strobes.size() - n0), 160'd0);
        check_output("rand_bad_staged", coefs(), w);
      end else begin
        wait_strobes(n0 + 1);
        check_output("rand_count", 160'(strobes.size() - n0), 160'd1);
        check_strobe("rand", n0, (k > 0) ? wcyc + 1 : last_xfer_cyc + 1, idx[2:0], w);
      end
    end

    // Reset asserted at data byte 10 of a frame.
    n0 = strobes.size();
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_frame(8'h04, w, 8'h00);
    for (int i = 0; i < 12; i++) apply_stimulus(frame_q[i]);
    bus.i_byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("midframe_reset");
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check_reset_outputs("after_midframe_reset");
    check_output("midframe_no_strobe", 160'(strobes.size() - n0), 160'd0);

    check_output("done_matches_strobe", 160'(done_mismatch), 160'd0);
    check_output("err_done_exclusive", 160'(both_high), 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
